// File: rtl/serial_cfg_shifter_if.sv
// Word handshake and status bundle between the link control logic and serial_cfg_shifter.
interface serial_cfg_if #(
  parameter int WIDTH = 24
);
  logic [WIDTH-1:0] wdata;
  logic             wvalid;
  logic             wready;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             busy;
  logic             mismatch;

  modport master (
    output wdata, wvalid,
    input  wready, rdata, rvalid, busy, mismatch
  );

  modport slave (
    input  wdata, wvalid,
    output wready, rdata, rvalid, busy, mismatch
  );
endinterface

// File: rtl/serial_cfg_shifter.sv
// Shifts one config word MSB-first into the external chain, pulses latch, and returns the old chain contents.
// Readback capture and mismatch detection are built only when CFG_READBACK_EN is defined.
module serial_cfg_shifter #(
  parameter int WIDTH        = 24,
  parameter int CLK_DIV      = 4,
  parameter int LATCH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  serial_cfg_if.slave cfg,
  output logic        sda_o,
  output logic        scl_o,
  output logic        latch_o,
  input  logic        sdi_i
);

  localparam int CNT_MAX = (CLK_DIV > LATCH_CYCLES) ? CLK_DIV : LATCH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  // Bits still to be sent after the one currently on sda_o.
  logic [WIDTH-2:0] shift_q, shift_d;
  logic sda_q, sda_d, scl_q, scl_d, latch_q, latch_d;
  logic rvalid_q, rvalid_d, busy_q, busy_d, wready_q, wready_d;
  logic accept;

  assign accept = (state_q == IDLE) && cfg.wvalid && wready_q;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    sda_d    = sda_q;
    scl_d    = scl_q;
    latch_d  = latch_q;
    rvalid_d = 1'b0;
    busy_d   = busy_q;
    wready_d = wready_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = SHIFT_LO;
          div_d    = '0;
          bit_d    = '0;
          shift_d  = cfg.wdata[WIDTH-2:0];
          sda_d    = cfg.wdata[WIDTH-1];
          scl_d    = 1'b0;
          busy_d   = 1'b1;
          wready_d = 1'b0;
        end
      end
      SHIFT_LO: begin
        if (div_q == DIV_LAST) begin
          state_d = SHIFT_HI;
          div_d   = '0;
          scl_d   = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          scl_d   = 1'b0;
          bit_d   = bit_q + 1'b1;
          shift_d = shift_q << 1;
          if (bit_q == BIT_LAST) begin
            state_d = LATCH;
            sda_d   = 1'b0;
            latch_d = 1'b1;
          end else begin
            state_d = SHIFT_LO;
            sda_d   = shift_q[WIDTH-2];
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      LATCH: begin
        if (div_q == LATCH_LAST) begin
          state_d  = DONE;
          div_d    = '0;
          latch_d  = 1'b0;
          rvalid_d = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DONE: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        wready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      sda_q    <= 1'b0;
      scl_q    <= 1'b0;
      latch_q  <= 1'b0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      wready_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sda_q    <= sda_d;
      scl_q    <= scl_d;
      latch_q  <= latch_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
      wready_q <= wready_d;
    end
  end

  always_ff @(posedge clk_i) begin
    shift_q <= shift_d;
  end

  assign sda_o      = sda_q;
  assign scl_o      = scl_q;
  assign latch_o    = latch_q;
  assign cfg.wready = wready_q;
  assign cfg.rvalid = rvalid_q;
  assign cfg.busy   = busy_q;

`ifdef CFG_READBACK_EN
  logic [WIDTH-1:0] cap_q, cap_d, word_q, word_d;
  logic [WIDTH-1:0] prev_q, prev_d, rdata_q, rdata_d;
  logic             have_prev_q, have_prev_d, mismatch_q, mismatch_d;

  // sdi_i is sampled on the edge that raises scl_o, before the chain shifts.
  always_comb begin
    cap_d       = cap_q;
    word_d      = word_q;
    prev_d      = prev_q;
    rdata_d     = rdata_q;
    have_prev_d = have_prev_q;
    mismatch_d  = mismatch_q;
    if (accept) word_d = cfg.wdata;
    if (state_q == SHIFT_LO && div_q == DIV_LAST) cap_d = {cap_q[WIDTH-2:0], sdi_i};
    if (state_q == LATCH && div_q == LATCH_LAST) begin
      rdata_d     = cap_q;
      prev_d      = word_q;
      have_prev_d = 1'b1;
      if (have_prev_q && (cap_q != prev_q)) mismatch_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q      <= '0;
      rdata_q     <= '0;
      have_prev_q <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      rdata_q     <= rdata_d;
      have_prev_q <= have_prev_d;
      mismatch_q  <= mismatch_d;
    end
  end

  always_ff @(posedge clk_i) begin
    cap_q  <= cap_d;
    word_q <= word_d;
  end

  assign cfg.rdata    = rdata_q;
  assign cfg.mismatch = mismatch_q;
`else
  logic unused_sdi;
  assign unused_sdi   = sdi_i;
  assign cfg.rdata    = '0;
  assign cfg.mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_serial_cfg_shifter.sv
// Bench for serial_cfg_shifter: external chain model, scoreboard of expected completions, negedge monitor.
module tb_serial_cfg_shifter;
  localparam int W   = 24;
  localparam int CD  = 4;
  localparam int LC  = 2;
  localparam int LAT = 2 * CD * W + LC + 1;
  localparam logic [W-1:0] ONE = 1;

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  logic sda, scl, latch, sdi;

  serial_cfg_if #(.WIDTH(W)) cfg_if ();

  serial_cfg_shifter #(.WIDTH(W), .CLK_DIV(CD), .LATCH_CYCLES(LC)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .cfg     (cfg_if),
    .sda_o   (sda),
    .scl_o   (scl),
    .latch_o (latch),
    .sdi_i   (sdi)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // External chain: shift register clocked by scl, parallel latch on latch rise.
  logic [W-1:0] chain = '0;
  logic [W-1:0] latched = '0;
  int latch_cnt = 0;
  event flip_ev;
  always begin
    @(posedge scl or flip_ev);
    if (scl) chain <= {chain[W-2:0], sda};
    else     chain <= chain ^ ONE;
  end
  always @(posedge latch) begin
    latched   <= chain;
    latch_cnt <= latch_cnt + 1;
  end
  assign sdi = chain[W-1];

  typedef struct {
    logic [W-1:0] word;
    logic [W-1:0] rdata;
    logic         mis;
    int           acc;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [W-1:0] m_prev = '0;
  logic         m_have = 1'b0;
  logic         m_mis  = 1'b0;

  int rv_cnt = 0, last_rv = -1000, rises = 0, lo_cnt = 0, hi_cnt = 0;
  logic scl_p = 1'b0, sda_p = 1'b0;

  always @(negedge clk) begin
    if (!rst_ni) begin
      lo_cnt = 0; hi_cnt = 0; rises = 0; scl_p = 1'b0; sda_p = 1'b0;
    end else begin
      if (scl && !scl_p) begin
        chk("scl_low_phase", lo_cnt, CD);
        lo_cnt = 0;
        rises++;
      end
      if (!scl && scl_p) begin
        chk("scl_high_phase", hi_cnt, CD);
        hi_cnt = 0;
      end
      if (scl && scl_p) chk("sda_stable_high", sda, sda_p);
      if (scl) hi_cnt++;
      else if (cfg_if.busy && !latch && !cfg_if.rvalid) lo_cnt++;
      else lo_cnt = 0;
      if (cfg_if.rvalid) begin
        rv_cnt++;
        last_rv = cyc;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rvalid_unexpected: got rvalid=1, want no completion pending");
        end else begin
          e = q.pop_front();
          chk("latency", cyc - e.acc, LAT);
          chk("rdata", cfg_if.rdata, e.rdata);
          chk("mismatch", cfg_if.mismatch, e.mis);
          chk("latched_word", latched, e.word);
          chk("scl_rises", rises, W);
          chk("busy_at_rvalid", cfg_if.busy, 1);
        end
        rises = 0;
      end
      scl_p = scl;
      sda_p = sda;
    end
  end

  task automatic check_reset_vals();
    chk("rst_wready", cfg_if.wready, 1);
    chk("rst_busy", cfg_if.busy, 0);
    chk("rst_rvalid", cfg_if.rvalid, 0);
    chk("rst_scl", scl, 0);
    chk("rst_sda", sda, 0);
    chk("rst_latch", latch, 0);
    chk("rst_mismatch", cfg_if.mismatch, 0);
    chk("rst_rdata", cfg_if.rdata, 0);
  endtask

  // Called at a negedge; leaves wvalid high, returns one cycle after the accept.
  task automatic send(input logic [W-1:0] w, input logic [W-1:0] er_in, input bit b2b);
    exp_t ex;
    logic [W-1:0] er;
    int n;
    er = er_in;
`ifndef CFG_READBACK_EN
    er = '0;
`endif
    cfg_if.wdata  = w;
    cfg_if.wvalid = 1'b1;
    n = 0;
    while (!cfg_if.wready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_if.wready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got wready=0 for %0d cycles, want accept", n);
    end else begin
      if (b2b) chk("b2b_accept_gap", cyc - last_rv, 1);
      ex.word  = w;
      ex.rdata = er;
      ex.acc   = cyc;
`ifdef CFG_READBACK_EN
      if (m_have && er != m_prev) m_mis = 1'b1;
`endif
      m_prev = w;
      m_have = 1'b1;
      ex.mis = m_mis;
      q.push_back(ex);
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got %0d pending completions, want 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  int lc0, rv0;

  initial begin
    cfg_if.wvalid = 1'b0;
    cfg_if.wdata  = '0;
    #1 rst_ni = 1'b0;
    #2 check_reset_vals();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    send(24'hA5C3F0, 24'h000000, 1'b0); cfg_if.wvalid = 1'b0; wait_idle();
    send(24'h123456, 24'hA5C3F0, 1'b0); cfg_if.wvalid = 1'b0; wait_idle();
    chk("mismatch_clean", cfg_if.mismatch, 0);
    -> flip_ev;
    @(negedge clk);
    send(24'h000001, 24'h123457, 1'b0); cfg_if.wvalid = 1'b0; wait_idle();

    send(24'hC0FFEE, 24'h000001, 1'b0);
    send(24'h3A5A5A, 24'hC0FFEE, 1'b1);
    cfg_if.wvalid = 1'b0;
    wait_idle();
    chk("mismatch_sticky", cfg_if.mismatch, m_mis);

    lc0 = latch_cnt;
    rv0 = rv_cnt;
    send(24'h5A5A5A, 24'h3A5A5A, 1'b0);
    cfg_if.wvalid = 1'b0;
    repeat (99) @(negedge clk);
    #2 rst_ni = 1'b0;
    q.delete();
    m_have = 1'b0; m_mis = 1'b0; m_prev = '0;
    #1 check_reset_vals();
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    repeat (250) @(negedge clk);
    chk("abort_no_latch", latch_cnt, lc0);
    chk("abort_no_rvalid", rv_cnt, rv0);

    send(24'h0F0F0F, chain, 1'b0);      cfg_if.wvalid = 1'b0; wait_idle();
    send(24'hF0F0F0, 24'h0F0F0F, 1'b0); cfg_if.wvalid = 1'b0; wait_idle();
    send(24'hFFFFFF, 24'hF0F0F0, 1'b0); cfg_if.wvalid = 1'b0; wait_idle();
    chk("mismatch_after_reset", cfg_if.mismatch, m_mis);
    chk("idle_wready", cfg_if.wready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish by %0t, want finish", $time);
    $fatal(1, "timeout");
  end
endmodule
